// File: rtl/execute_stage.sv
// Execute stage of the 5-stage MIPS pipeline: ID/EX register with flush,
// operand forwarding muxes, ALUSrc/RegDst muxes, ALU and EX/MEM register.
module execute_stage #(
    parameter int WIDTH   = 32,
    parameter int REGBITS = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               FlushE,
    input  logic               RegWriteD,
    input  logic               MemtoRegD,
    input  logic               MemWriteD,
    input  logic [2:0]         ALUControlD,
    input  logic               ALUSrcD,
    input  logic               RegDstD,
    input  logic [WIDTH-1:0]   RD1D,
    input  logic [WIDTH-1:0]   RD2D,
    input  logic [WIDTH-1:0]   SignImmD,
    input  logic [REGBITS-1:0] rsD,
    input  logic [REGBITS-1:0] rtD,
    input  logic [REGBITS-1:0] rdD,
    input  logic [1:0]         ForwardAE,
    input  logic [1:0]         ForwardBE,
    input  logic [WIDTH-1:0]   ResultW,
    output logic [REGBITS-1:0] rsE,
    output logic [REGBITS-1:0] rtE,
    output logic               RegWriteE,
    output logic               MemtoRegE,
    output logic               RegWriteM,
    output logic               MemtoRegM,
    output logic               MemWriteM,
    output logic [WIDTH-1:0]   ALUOutM,
    output logic [WIDTH-1:0]   WriteDataM,
    output logic [REGBITS-1:0] WriteRegM,
    output logic               ZeroM
);

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    // ID/EX state
    logic               regwrite_e_q, regwrite_e_d;
    logic               memtoreg_e_q, memtoreg_e_d;
    logic               memwrite_e_q, memwrite_e_d;
    logic [2:0]         alucontrol_e_q, alucontrol_e_d;
    logic               alusrc_e_q, alusrc_e_d;
    logic               regdst_e_q, regdst_e_d;
    logic [WIDTH-1:0]   rd1_e_q, rd1_e_d;
    logic [WIDTH-1:0]   rd2_e_q, rd2_e_d;
    logic [WIDTH-1:0]   signimm_e_q, signimm_e_d;
    logic [REGBITS-1:0] rs_e_q, rs_e_d;
    logic [REGBITS-1:0] rt_e_q, rt_e_d;
    logic [REGBITS-1:0] rd_e_q, rd_e_d;

    // EX/MEM state
    logic               regwrite_m_q, regwrite_m_d;
    logic               memtoreg_m_q, memtoreg_m_d;
    logic               memwrite_m_q, memwrite_m_d;
    logic [WIDTH-1:0]   aluout_m_q, aluout_m_d;
    logic [WIDTH-1:0]   writedata_m_q, writedata_m_d;
    logic [REGBITS-1:0] writereg_m_q, writereg_m_d;
    logic               zero_m_q, zero_m_d;

    // Execute-stage combinational values
    logic [WIDTH-1:0]   src_a_e;
    logic [WIDTH-1:0]   src_b_e;
    logic [WIDTH-1:0]   writedata_e;
    logic [WIDTH-1:0]   alu_result_e;
    logic [REGBITS-1:0] writereg_e;

    // ID/EX next state: capture decode outputs, or a bubble when flushed
    always_comb begin
        regwrite_e_d   = RegWriteD;
        memtoreg_e_d   = MemtoRegD;
        memwrite_e_d   = MemWriteD;
        alucontrol_e_d = ALUControlD;
        alusrc_e_d     = ALUSrcD;
        regdst_e_d     = RegDstD;
        rd1_e_d        = RD1D;
        rd2_e_d        = RD2D;
        signimm_e_d    = SignImmD;
        rs_e_d         = rsD;
        rt_e_d         = rtD;
        rd_e_d         = rdD;
        if (FlushE) begin
            regwrite_e_d   = 1'b0;
            memtoreg_e_d   = 1'b0;
            memwrite_e_d   = 1'b0;
            alucontrol_e_d = '0;
            alusrc_e_d     = 1'b0;
            regdst_e_d     = 1'b0;
            rd1_e_d        = '0;
            rd2_e_d        = '0;
            signimm_e_d    = '0;
            rs_e_d         = '0;
            rt_e_d         = '0;
            rd_e_d         = '0;
        end
    end

    // Forwarding muxes, ALUSrc/RegDst muxes and the ALU; ALUOutM source is the
    // registered value, so there is no path from the ALU back into its inputs
    always_comb begin
        unique case (fwd_sel_e'(ForwardAE))
            FWD_WB:  src_a_e = ResultW;
            FWD_MEM: src_a_e = aluout_m_q;
            default: src_a_e = rd1_e_q;
        endcase

        unique case (fwd_sel_e'(ForwardBE))
            FWD_WB:  writedata_e = ResultW;
            FWD_MEM: writedata_e = aluout_m_q;
            default: writedata_e = rd2_e_q;
        endcase

        src_b_e = alusrc_e_q ? signimm_e_q : writedata_e;

        unique case (alu_op_e'(alucontrol_e_q))
            ALU_ADD: alu_result_e = src_a_e + src_b_e;
            ALU_SUB: alu_result_e = src_a_e - src_b_e;
            ALU_AND: alu_result_e = src_a_e & src_b_e;
            ALU_OR:  alu_result_e = src_a_e | src_b_e;
            ALU_SLT: alu_result_e = {{(WIDTH-1){1'b0}}, ($signed(src_a_e) < $signed(src_b_e))};
            default: alu_result_e = '0;
        endcase

        writereg_e = regdst_e_q ? rd_e_q : rt_e_q;
    end

    // EX/MEM next state: unconditional capture of the execute results
    always_comb begin
        regwrite_m_d  = regwrite_e_q;
        memtoreg_m_d  = memtoreg_e_q;
        memwrite_m_d  = memwrite_e_q;
        aluout_m_d    = alu_result_e;
        writedata_m_d = writedata_e;
        writereg_m_d  = writereg_e;
        zero_m_d      = (alu_result_e == '0);
    end

    // ID/EX register with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regwrite_e_q   <= 1'b0;
            memtoreg_e_q   <= 1'b0;
            memwrite_e_q   <= 1'b0;
            alucontrol_e_q <= '0;
            alusrc_e_q     <= 1'b0;
            regdst_e_q     <= 1'b0;
            rd1_e_q        <= '0;
            rd2_e_q        <= '0;
            signimm_e_q    <= '0;
            rs_e_q         <= '0;
            rt_e_q         <= '0;
            rd_e_q         <= '0;
        end else begin
            regwrite_e_q   <= regwrite_e_d;
            memtoreg_e_q   <= memtoreg_e_d;
            memwrite_e_q   <= memwrite_e_d;
            alucontrol_e_q <= alucontrol_e_d;
            alusrc_e_q     <= alusrc_e_d;
            regdst_e_q     <= regdst_e_d;
            rd1_e_q        <= rd1_e_d;
            rd2_e_q        <= rd2_e_d;
            signimm_e_q    <= signimm_e_d;
            rs_e_q         <= rs_e_d;
            rt_e_q         <= rt_e_d;
            rd_e_q         <= rd_e_d;
        end
    end

    // EX/MEM register with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regwrite_m_q  <= 1'b0;
            memtoreg_m_q  <= 1'b0;
            memwrite_m_q  <= 1'b0;
            aluout_m_q    <= '0;
            writedata_m_q <= '0;
            writereg_m_q  <= '0;
            zero_m_q      <= 1'b0;
        end else begin
            regwrite_m_q  <= regwrite_m_d;
            memtoreg_m_q  <= memtoreg_m_d;
            memwrite_m_q  <= memwrite_m_d;
            aluout_m_q    <= aluout_m_d;
            writedata_m_q <= writedata_m_d;
            writereg_m_q  <= writereg_m_d;
            zero_m_q      <= zero_m_d;
        end
    end

    assign rsE        = rs_e_q;
    assign rtE        = rt_e_q;
    assign RegWriteE  = regwrite_e_q;
    assign MemtoRegE  = memtoreg_e_q;
    assign RegWriteM  = regwrite_m_q;
    assign MemtoRegM  = memtoreg_m_q;
    assign MemWriteM  = memwrite_m_q;
    assign ALUOutM    = aluout_m_q;
    assign WriteDataM = writedata_m_q;
    assign WriteRegM  = writereg_m_q;
    assign ZeroM      = zero_m_q;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: instruction-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_execute_stage;

    typedef struct packed {
        logic        rw;
        logic        mtr;
        logic        mw;
        logic [2:0]  op;
        logic        alusrc;
        logic        regdst;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } instr_t;

    typedef struct packed {
        logic        rw;
        logic        mtr;
        logic        mw;
        logic [31:0] aluout;
        logic [31:0] wdata;
        logic [4:0]  wreg;
        logic        zero;
    } mres_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        FlushE = 1'b0;
    logic [1:0]  ForwardAE = 2'b00;
    logic [1:0]  ForwardBE = 2'b00;
    logic [31:0] ResultW = '0;
    instr_t      d = '0;

    logic [4:0]  rsE, rtE, WriteRegM;
    logic        RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, MemWriteM, ZeroM;
    logic [31:0] ALUOutM, WriteDataM;

    int tests = 0;
    int fails = 0;
    logic check_en = 1'b0;

    execute_stage #(.WIDTH(32), .REGBITS(5)) dut (
        .clk(clk), .reset(reset), .FlushE(FlushE),
        .RegWriteD(d.rw), .MemtoRegD(d.mtr), .MemWriteD(d.mw),
        .ALUControlD(d.op), .ALUSrcD(d.alusrc), .RegDstD(d.regdst),
        .RD1D(d.rd1), .RD2D(d.rd2), .SignImmD(d.imm),
        .rsD(d.rs), .rtD(d.rt), .rdD(d.rd),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
        .rsE(rsE), .rtE(rtE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
        .ZeroM(ZeroM)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what one instruction in E produces in M
    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] reg_v,
                                         input logic [31:0] wb, input logic [31:0] mem);
        if (sel == 2'b01) return wb;
        if (sel == 2'b10) return mem;
        return reg_v;
    endfunction

    function automatic mres_t execute(input instr_t e, input logic [1:0] fa, input logic [1:0] fb,
                                      input logic [31:0] wb, input logic [31:0] prev);
        mres_t r;
        logic [31:0] a, b, wd, res;
        a  = pick(fa, e.rd1, wb, prev);
        wd = pick(fb, e.rd2, wb, prev);
        b  = e.alusrc ? e.imm : wd;
        case (e.op)
            3'b010:  res = a + b;
            3'b110:  res = a - b;
            3'b000:  res = a & b;
            3'b001:  res = a | b;
            3'b111:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: res = 32'd0;
        endcase
        r.rw = e.rw; r.mtr = e.mtr; r.mw = e.mw;
        r.aluout = res; r.wdata = wd;
        r.wreg = e.regdst ? e.rd : e.rt;
        r.zero = (res == 32'd0);
        return r;
    endfunction

    instr_t m_e = '0;
    mres_t  m_m = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_e <= '0;
            m_m <= '0;
        end else begin
            m_m <= execute(m_e, ForwardAE, ForwardBE, ResultW, m_m.aluout);
            m_e <= FlushE ? '0 : d;
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (check_en) begin
            chk("rsE", rsE, m_e.rs);
            chk("rtE", rtE, m_e.rt);
            chk("RegWriteE", RegWriteE, m_e.rw);
            chk("MemtoRegE", MemtoRegE, m_e.mtr);
            chk("RegWriteM", RegWriteM, m_m.rw);
            chk("MemtoRegM", MemtoRegM, m_m.mtr);
            chk("MemWriteM", MemWriteM, m_m.mw);
            chk("ALUOutM", ALUOutM, m_m.aluout);
            chk("WriteDataM", WriteDataM, m_m.wdata);
            chk("WriteRegM", WriteRegM, m_m.wreg);
            chk("ZeroM", ZeroM, m_m.zero);
        end
    end

    function automatic instr_t mk(input logic [2:0] op, input logic [31:0] rd1, input logic [31:0] rd2,
                                  input logic [31:0] imm, input logic alusrc, input logic regdst,
                                  input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                  input logic rw, input logic mw);
        instr_t i;
        i.rw = rw; i.mtr = 1'b0; i.mw = mw; i.op = op;
        i.alusrc = alusrc; i.regdst = regdst;
        i.rd1 = rd1; i.rd2 = rd2; i.imm = imm;
        i.rs = rs; i.rt = rt; i.rd = rd;
        return i;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ":rsE"}, rsE, 0);
        chk({tag, ":rtE"}, rtE, 0);
        chk({tag, ":ctlE"}, {RegWriteE, MemtoRegE}, 0);
        chk({tag, ":ctlM"}, {RegWriteM, MemtoRegM, MemWriteM, ZeroM}, 0);
        chk({tag, ":ALUOutM"}, ALUOutM, 0);
        chk({tag, ":WriteDataM"}, WriteDataM, 0);
        chk({tag, ":WriteRegM"}, WriteRegM, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset = 1'b1;
        d = instr_t'({$urandom, $urandom, $urandom, $urandom});
        check_en = 1'b1;
        tick;
        tick;
        chk_all_zero("reset");
        @(negedge clk);
        #1 reset = 1'b0;
        d = '0;

        // add $3 = $1 + $2
        d = mk(3'b010, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
        tick;
        d = '0;
        tick;
        chk("add:ALUOutM", ALUOutM, 32'd12);
        chk("add:WriteRegM", WriteRegM, 32'd3);
        chk("add:RegWriteM", RegWriteM, 32'd1);

        // flushed store/regwrite becomes a bubble
        d = mk(3'b010, 32'd9, 32'd9, 32'd0, 1'b0, 1'b0, 5'd4, 5'd5, 5'd6, 1'b1, 1'b1);
        FlushE = 1'b1;
        tick;
        FlushE = 1'b0;
        d = '0;
        chk("flush:RegWriteE", RegWriteE, 0);
        chk("flush:MemtoRegE", MemtoRegE, 0);
        chk("flush:rsE", rsE, 0);
        chk("flush:rtE", rtE, 0);
        tick;
        chk("flush:MemWriteM", MemWriteM, 0);
        chk("flush:RegWriteM", RegWriteM, 0);

        // back-to-back forwarding from M, then from W
        d = mk(3'b010, 32'd100, 32'd0, 32'd0, 1'b0, 1'b1, 5'd1, 5'd0, 5'd8, 1'b1, 1'b0);
        tick;
        d = mk(3'b010, 32'd1, 32'd0, 32'd4, 1'b1, 1'b0, 5'd8, 5'd9, 5'd0, 1'b1, 1'b0);
        tick;
        chk("fwd:ALUOutM_prev", ALUOutM, 32'd100);
        ForwardAE = 2'b10;
        tick;
        chk("fwdM:ALUOutM", ALUOutM, 32'd104);
        ForwardAE = 2'b01;
        ResultW = 32'd50;
        d = '0;
        tick;
        chk("fwdW:ALUOutM", ALUOutM, 32'd54);
        ForwardAE = 2'b00;

        // store data forwarded from W while the ALU uses the immediate
        d = mk(3'b010, 32'h1000, 32'h1111, 32'd8, 1'b1, 1'b0, 5'd2, 5'd7, 5'd0, 1'b0, 1'b1);
        tick;
        d = '0;
        ForwardBE = 2'b01;
        ResultW = 32'hDEAD;
        tick;
        ForwardBE = 2'b00;
        chk("store:WriteDataM", WriteDataM, 32'hDEAD);
        chk("store:ALUOutM", ALUOutM, 32'h1008);
        chk("store:MemWriteM", MemWriteM, 1);
        chk("store:WriteRegM", WriteRegM, 7);

        // slt, sub to zero, undefined op
        d = mk(3'b111, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        tick;
        d = mk(3'b110, 32'd5, 32'd5, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        tick;
        chk("slt:ALUOutM", ALUOutM, 32'd1);
        chk("slt:ZeroM", ZeroM, 0);
        d = mk(3'b011, 32'd9, 32'd3, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        tick;
        chk("sub:ALUOutM", ALUOutM, 32'd0);
        chk("sub:ZeroM", ZeroM, 1);
        d = mk(3'b000, 32'hF0F0, 32'h0FF0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        tick;
        chk("undef:ALUOutM", ALUOutM, 32'd0);
        d = '0;
        tick;
        chk("and:ALUOutM", ALUOutM, 32'h00F0);

        // asynchronous reset with two instructions in flight
        d = mk(3'b010, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
        tick;
        d = mk(3'b110, 32'd20, 32'd3, 32'd0, 1'b0, 1'b1, 5'd4, 5'd5, 5'd6, 1'b1, 1'b0);
        tick;
        #2 reset = 1'b1;
        #1 chk_all_zero("midreset");
        reset = 1'b0;
        d = mk(3'b001, 32'hF0, 32'h0F, 32'd0, 1'b0, 1'b1, 5'd10, 5'd11, 5'd9, 1'b1, 1'b0);
        tick;
        chk("postreset:RegWriteE", RegWriteE, 1);
        chk("postreset:rsE", rsE, 10);
        chk("postreset:rtE", rtE, 11);
        d = '0;
        tick;
        chk("postreset:ALUOutM", ALUOutM, 32'hFF);
        chk("postreset:WriteRegM", WriteRegM, 9);

        // random traffic checked by the model
        for (int i = 0; i < 300; i++) begin
            d = instr_t'({$urandom, $urandom, $urandom, $urandom});
            if ($urandom_range(0, 3) == 0) d.rd2 = d.rd1;
            if ($urandom_range(0, 3) == 0) d.rd1 = {{28{d.rd1[31]}}, d.rd1[3:0]};
            FlushE    = ($urandom_range(0, 7) == 0);
            ForwardAE = 2'($urandom_range(0, 3));
            ForwardBE = 2'($urandom_range(0, 3));
            ResultW   = $urandom;
            tick;
            if ($urandom_range(0, 49) == 0) begin
                #2 reset = 1'b1;
                #1 reset = 1'b0;
            end
        end

        @(negedge clk);
        #1 check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
